// File: rtl/if_fetch_stage_pkg.sv
// Shared CPU definitions: fetch-stage state encoding, bubble instruction and
// the J-type target helper also used by the ID stage.
package if_fetch_stage_pkg;

  typedef enum logic {
    RUN,
    DROP
  } if_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                              input logic [31:0] instr);
    return {pc4[31:28], instr[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register with load/hold/bubble controls and a one-entry
// buffer for a word that returns while the stage is stalled.
module if_id_reg
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP = NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        load_hold_i,
  input  logic        bubble_i,
  input  logic        hold_wr_i,
  input  logic        hold_clr_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] pc4_i,
  output logic        hold_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc4_o,
  output logic        valid_o
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc4_q, hold_pc4_d;

  always_comb begin
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    valid_d      = valid_q;
    hold_valid_d = hold_valid_q;
    hold_instr_d = hold_instr_q;
    hold_pc4_d   = hold_pc4_q;

    if (bubble_i) begin
      instr_d = NOP;
      pc4_d   = '0;
      valid_d = 1'b0;
    end else if (load_hold_i) begin
      instr_d = hold_instr_q;
      pc4_d   = hold_pc4_q;
      valid_d = 1'b1;
    end else if (load_i) begin
      instr_d = rdata_i;
      pc4_d   = pc4_i;
      valid_d = 1'b1;
    end

    if (hold_clr_i) begin
      hold_valid_d = 1'b0;
    end else if (hold_wr_i) begin
      hold_valid_d = 1'b1;
      hold_instr_d = rdata_i;
      hold_pc4_d   = pc4_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q      <= NOP;
      pc4_q        <= '0;
      valid_q      <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_instr_q <= NOP;
      hold_pc4_q   <= '0;
    end else begin
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
      hold_valid_q <= hold_valid_d;
      hold_instr_q <= hold_instr_d;
      hold_pc4_q   <= hold_pc4_d;
    end
  end

  assign hold_valid_o = hold_valid_q;
  assign instr_o      = instr_q;
  assign pc4_o        = pc4_q;
  assign valid_o      = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, instruction-memory request handshake, redirect
// and flush handling, and the IF/ID register.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        CHmux,
  input  logic        IFFlush,
  input  logic        Jump,
  input  logic [31:0] branch_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction_id,
  output logic [31:0] PC_plus4_id,
  output logic        valid_id,
  output logic [15:0] flush_count
);

  if_state_t   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        out_pend_q, out_pend_d;
  logic [31:0] saved_target_q, saved_target_d;
  logic [15:0] flush_count_q, flush_count_d;

  logic        hold_valid;
  logic        redir_acc, flush_acc, xfer;
  logic [31:0] target, pc_plus4;
  logic        id_load, id_load_hold, id_bubble, hold_wr, hold_clr;

  assign redir_acc = CHmux & ~stall;
  assign flush_acc = IFFlush & ~stall;
  assign target    = Jump ? jump_target(PC_plus4_id, Instruction_id) : branch_target;
  assign pc_plus4  = pc_q + 32'd4;

  // Gating with rst_n makes a late imem_ready during reset harmless.
  assign imem_req  = rst_n & ((state_q == DROP) | out_pend_q | (~hold_valid & ~stall));
  assign imem_addr = pc_q;
  assign xfer      = imem_req & imem_ready;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    saved_target_d = saved_target_q;
    id_load        = 1'b0;
    id_load_hold   = 1'b0;
    id_bubble      = 1'b0;
    hold_wr        = 1'b0;
    hold_clr       = 1'b0;

    case (state_q)
      RUN: begin
        if (xfer) begin
          if (redir_acc | flush_acc) begin
            pc_d      = redir_acc ? target : pc_plus4;
            id_bubble = 1'b1;
          end else if (stall) begin
            hold_wr = 1'b1;
            pc_d    = pc_plus4;
          end else begin
            id_load = 1'b1;
            pc_d    = pc_plus4;
          end
        end else if (redir_acc & imem_req) begin
          // Outstanding request must finish at its address before redirecting.
          saved_target_d = target;
          state_d        = DROP;
          id_bubble      = 1'b1;
        end else if (redir_acc) begin
          pc_d      = target;
          hold_clr  = 1'b1;
          id_bubble = 1'b1;
        end else if (stall) begin
          // Everything holds.
        end else if (hold_valid) begin
          id_load_hold = 1'b1;
          hold_clr     = 1'b1;
        end else begin
          id_bubble = 1'b1;
        end
      end
      DROP: begin
        id_bubble = 1'b1;
        if (redir_acc) saved_target_d = target;
        if (xfer) begin
          pc_d    = redir_acc ? target : saved_target_q;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign out_pend_d    = imem_req & ~imem_ready;
  assign flush_count_d = (flush_acc && flush_count_q != '1) ? flush_count_q + 16'd1
                                                            : flush_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      pc_q           <= RESET_PC;
      out_pend_q     <= 1'b0;
      saved_target_q <= '0;
      flush_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      out_pend_q     <= out_pend_d;
      saved_target_q <= saved_target_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign flush_count = flush_count_q;

  if_id_reg #(
    .NOP(NOP)
  ) u_if_id_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (id_load),
    .load_hold_i (id_load_hold),
    .bubble_i    (id_bubble),
    .hold_wr_i   (hold_wr),
    .hold_clr_i  (hold_clr),
    .rdata_i     (imem_rdata),
    .pc4_i       (pc_plus4),
    .hold_valid_o(hold_valid),
    .instr_o     (Instruction_id),
    .pc4_o       (PC_plus4_id),
    .valid_o     (valid_id)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios with literal expectations plus
// a cycle-level reference model checked on every falling edge.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        CHmux = 1'b0, IFFlush = 1'b0, Jump = 1'b0, stall = 1'b0;
  logic        imem_ready = 1'b1;
  logic [31:0] branch_target = 32'h0;
  logic        imem_req, valid_id;
  logic [31:0] imem_addr, imem_rdata, Instruction_id, PC_plus4_id;
  logic [15:0] flush_count;
  logic        ovr_en = 1'b0;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  if_fetch_stage #(
    .RESET_PC(32'h0000_0000),
    .NOP     (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .CHmux         (CHmux),
    .IFFlush       (IFFlush),
    .Jump          (Jump),
    .branch_target (branch_target),
    .stall         (stall),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .Instruction_id(Instruction_id),
    .PC_plus4_id   (PC_plus4_id),
    .valid_id      (valid_id),
    .flush_count   (flush_count)
  );

  // Memory image: word i holds 0x1000+i, optionally with a j at address 4.
  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic ov);
    if (ov && a == 32'h4) return 32'h0800_0040;
    return 32'h1000 + {2'b00, a[31:2]};
  endfunction

  assign imem_rdata = mem_word(imem_addr, ovr_en);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model
  logic [31:0] m_pc, m_tgt, m_instr, m_pc4;
  logic        m_drop, m_pend, m_valid;
  int          m_fc;
  logic [63:0] m_hold[$];

  function automatic logic m_req();
    return rst_n && (m_drop || m_pend || (m_hold.size() == 0 && !stall));
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic        req, xfer, redir, fl;
    logic [31:0] tgt, word;
    logic [63:0] e;
    if (!rst_n) begin
      m_pc = 32'h0; m_tgt = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
      m_drop = 1'b0; m_pend = 1'b0; m_valid = 1'b0; m_fc = 0;
      m_hold.delete();
    end else begin
      req   = m_req();
      xfer  = req && imem_ready;
      redir = CHmux && !stall;
      fl    = IFFlush && !stall;
      tgt   = Jump ? {m_pc4[31:28], m_instr[25:0], 2'b00} : branch_target;
      word  = mem_word(m_pc, ovr_en);
      if (m_drop) begin
        if (redir) m_tgt = tgt;
        m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        if (xfer) begin m_pc = m_tgt; m_drop = 1'b0; end
      end else if (xfer) begin
        if (redir || fl) begin
          m_pc = redir ? tgt : m_pc + 32'd4;
          m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (stall) begin
          m_hold.push_back({word, m_pc + 32'd4});
          m_pc = m_pc + 32'd4;
        end else begin
          m_instr = word; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
          m_pc = m_pc + 32'd4;
        end
      end else if (redir && req) begin
        m_tgt = tgt; m_drop = 1'b1;
        m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      end else if (redir) begin
        m_pc = tgt; m_hold.delete();
        m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      end else if (stall) begin
      end else if (m_hold.size() != 0) begin
        e = m_hold.pop_front();
        m_instr = e[63:32]; m_pc4 = e[31:0]; m_valid = 1'b1;
      end else begin
        m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      end
      m_pend = req && !imem_ready;
      if (fl && m_fc < 65535) m_fc++;
    end
  end

  always @(negedge clk) begin
    chk("m_req", 32'(imem_req), 32'(m_req()));
    chk("m_addr", imem_addr, m_pc);
    chk("m_instr", Instruction_id, m_instr);
    chk("m_pc4", PC_plus4_id, m_pc4);
    chk("m_valid", 32'(valid_id), 32'(m_valid));
    chk("m_fc", 32'(flush_count), 32'(m_fc));
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr", Instruction_id, 32'h0);
    chk("rst_pc4", PC_plus4_id, 32'h0);
    chk("rst_valid", 32'(valid_id), 32'h0);
    chk("rst_fc", 32'(flush_count), 32'h0);

    // Streaming fetch
    next(); rst_n = 1'b1; #1;
    chk("s_addr0", imem_addr, 32'h0);
    chk("s_req0", 32'(imem_req), 32'h1);
    next(); #1;
    chk("s_addr1", imem_addr, 32'h4);
    chk("s_instr1", Instruction_id, 32'h1000);
    chk("s_valid1", 32'(valid_id), 32'h1);
    next(); #1;
    chk("s_addr2", imem_addr, 32'h8);
    chk("s_instr2", Instruction_id, 32'h1001);
    chk("s_pc4_2", PC_plus4_id, 32'h8);

    // Jump redirect with flush
    next(); rst_n = 1'b0; ovr_en = 1'b1;
    next(); rst_n = 1'b1;
    next();
    next(); CHmux = 1'b1; IFFlush = 1'b1; Jump = 1'b1; #1;
    chk("j_instr", Instruction_id, 32'h0800_0040);
    chk("j_pc4", PC_plus4_id, 32'h8);
    next(); CHmux = 1'b0; IFFlush = 1'b0; Jump = 1'b0; #1;
    chk("j_addr", imem_addr, 32'h100);
    chk("j_bubble", 32'(valid_id), 32'h0);
    chk("j_fc", 32'(flush_count), 32'h1);
    next(); #1;
    chk("j_instr2", Instruction_id, 32'h1040);
    chk("j_addr2", imem_addr, 32'h104);

    // Redirect ignored under stall
    stall = 1'b1; CHmux = 1'b1; branch_target = 32'h300; #1;
    chk("cs_req", 32'(imem_req), 32'h0);
    next(); stall = 1'b0; CHmux = 1'b0; #1;
    chk("cs_addr", imem_addr, 32'h104);
    chk("cs_instr", Instruction_id, 32'h1040);
    chk("cs_valid", 32'(valid_id), 32'h1);
    chk("cs_fc", 32'(flush_count), 32'h1);

    // Word returned during a 3-cycle stall lands in the hold buffer
    next(); imem_ready = 1'b0; #1;
    chk("h_addr0", imem_addr, 32'h108);
    next(); imem_ready = 1'b1; stall = 1'b1; #1;
    chk("h_req1", 32'(imem_req), 32'h1);
    next(); #1;
    chk("h_req2", 32'(imem_req), 32'h0);
    chk("h_addr2", imem_addr, 32'h10C);
    chk("h_valid2", 32'(valid_id), 32'h0);
    next();
    next(); stall = 1'b0; #1;
    chk("h_req_rel", 32'(imem_req), 32'h0);
    next(); #1;
    chk("h_instr", Instruction_id, 32'h1042);
    chk("h_pc4", PC_plus4_id, 32'h10C);
    chk("h_req", 32'(imem_req), 32'h1);
    next(); #1;
    chk("h_instr_n", Instruction_id, 32'h1043);

    // Redirect while the request waits for two more cycles
    CHmux = 1'b1; branch_target = 32'h200; imem_ready = 1'b0; #1;
    chk("d_addr0", imem_addr, 32'h110);
    next(); CHmux = 1'b0; #1;
    chk("d_addr1", imem_addr, 32'h110);
    chk("d_req1", 32'(imem_req), 32'h1);
    next(); #1;
    chk("d_addr2", imem_addr, 32'h110);
    next(); imem_ready = 1'b1; #1;
    chk("d_valid3", 32'(valid_id), 32'h0);
    next(); #1;
    chk("d_addr_t", imem_addr, 32'h200);
    chk("d_valid_t", 32'(valid_id), 32'h0);
    next(); #1;
    chk("d_instr", Instruction_id, 32'h1080);

    // PC wrap-around
    CHmux = 1'b1; branch_target = 32'hFFFF_FFFC; #1;
    next(); CHmux = 1'b0; #1;
    chk("w_addr", imem_addr, 32'hFFFF_FFFC);
    next(); #1;
    chk("w_addr0", imem_addr, 32'h0);
    chk("w_pc4", PC_plus4_id, 32'h0);
    chk("w_valid", 32'(valid_id), 32'h1);
    chk("w_instr", Instruction_id, 32'h4000_0FFF);

    // Reset mid-transfer
    imem_ready = 1'b0;
    next(); rst_n = 1'b0; #1;
    chk("r_req", 32'(imem_req), 32'h0);
    imem_ready = 1'b1;
    next(); #1;
    chk("r_req2", 32'(imem_req), 32'h0);
    chk("r_addr", imem_addr, 32'h0);
    rst_n = 1'b1; ovr_en = 1'b0;

    // Flush counter saturation
    next(); IFFlush = 1'b1;
    repeat (65534) next();
    #1 chk("f_65534", 32'(flush_count), 32'd65534);
    next(); #1;
    chk("f_sat", 32'(flush_count), 32'hFFFF);
    repeat (5) next();
    #1 chk("f_sat2", 32'(flush_count), 32'hFFFF);
    IFFlush = 1'b0;
    repeat (2) next();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the 5-stage pipelined CPU: owns the PC, drives the instruction-memory request handshake and the IF/ID pipeline register. It consumes the redirect (`CHmux`) and flush (`IFFlush`) decisions from the control hazard unit and the load-use `stall` from the data hazard unit. It sits directly upstream of the ID stage and the hazard logic.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `NOP`, 32'h0000_0000, instruction word inserted for a bubble

- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `CHmux` in 1: redirect PC to the ID-stage target
- `IFFlush` in 1: squash the instruction entering IF/ID
- `Jump` in 1: target select, 1 = jump target, 0 = `branch_target`
- `branch_target` in 32: branch target computed in ID
- `stall` in 1: load-use stall; freeze PC and IF/ID
- `imem_req` out 1: fetch request
- `imem_addr` out 32: fetch address, equals PC
- `imem_ready` in 1: `imem_rdata` valid; the transfer completes when `imem_req & imem_ready`
- `imem_rdata` in 32: fetched word
- `Instruction_id` out 32: IF/ID instruction
- `PC_plus4_id` out 32: IF/ID PC+4
- `valid_id` out 1: IF/ID holds a real instruction
- `flush_count` out 16: saturating count of accepted flushes

## Operation
**Target and accept rules**
- Jump target = `{PC_plus4_id[31:28], Instruction_id[25:0], 2'b00}`.
- `stall` has priority over `CHmux` and `IFFlush`. While `stall` is high, both are ignored; the branch in ID re-evaluates next cycle.
- Accepted redirect = `CHmux & !stall`. Accepted flush = `IFFlush & !stall`.

**State and request**
- State register: `RUN`, `DROP`.
- Internal registers:
  - `out_pend`: request issued last cycle, not yet completed.
  - `hold_valid`, `hold_instr`, `hold_pc4`: one-entry buffer for a word returned during a stall.
  - `saved_target`.
- `imem_req` = 0 while `rst_n` low; otherwise `out_pend | (!hold_valid & !stall)`.
- `imem_addr` must stay stable while `imem_req & !imem_ready`.

**RUN, transfer completes**
- Redirect or flush accepted: discard data. PC <= target if redirect, else PC+4. IF/ID <= bubble.
- Else `stall`: hold buffer <= (`rdata`, PC+4). PC <= PC+4. IF/ID unchanged.
- Else: IF/ID <= (`rdata`, PC+4, valid 1). PC <= PC+4.

**RUN, no transfer**
- Redirect accepted while a request is outstanding (`imem_req` high, not ready): `saved_target` <= target, go to `DROP`, IF/ID <= bubble.
- Redirect accepted with no request outstanding: PC <= target, clear `hold_valid`, IF/ID <= bubble.
- `stall`: everything holds.
- `hold_valid & !stall`: IF/ID <= hold entry, clear `hold_valid`.
- Otherwise: IF/ID <= bubble (`NOP`, valid 0).

**DROP**
- `imem_req` = 1 at the same address; IF/ID is a bubble every cycle.
- A redirect accepted in `DROP` overwrites `saved_target`.
- On transfer: discard data, PC <= `saved_target`, go to `RUN`.

**flush_count**
- Increments on each accepted flush; saturates at 16'hFFFF.

## Timing
- Reset values: PC=`RESET_PC`, `Instruction_id`=`NOP`, `PC_plus4_id`=0, `valid_id`=0, state `RUN`, `out_pend`=0, `hold_valid`=0, `flush_count`=0, `imem_req`=0.
- With `imem_ready` tied 1: fetch-to-IF/ID latency is 1 cycle, throughput 1 instruction per cycle.
- A redirect in cycle N puts the target on `imem_addr` in cycle N+1, with exactly one bubble, provided no request is outstanding. Each extra wait cycle of the abandoned request adds one bubble.
- Stall release with `hold_valid` set: the held word enters IF/ID that cycle and `imem_req` is 0; fetch resumes the next cycle.
- PC arithmetic is modulo 2^32; PC+4 from 32'hFFFF_FFFC wraps to 0.
- Reset asserted mid-transfer aborts immediately; any late `imem_ready` is ignored because `imem_req` is 0.

## Structure
- Shared CPU package:
  - `if_state_t` enum {`RUN`, `DROP`}
  - `NOP_INSTR` constant
  - `jump_target(pc4, instr)` function, reused by the ID stage
- One sub-module, `if_id_reg`: the IF/ID register with load, hold and bubble controls, plus the hold buffer mux.

## Test plan
- Reset release, `imem_ready`=1, memory returns words 0x1000..: `imem_addr` reads 0,4,8 on consecutive cycles; `Instruction_id` follows 1 cycle later with `valid_id`=1.
- `Instruction_id`=0x0800_0040 (j), `PC_plus4_id`=0x0000_0008, `CHmux`=`IFFlush`=`Jump`=1 for one cycle -> next `imem_addr`=0x0000_0100, one bubble, `flush_count`=1.
- `stall` high 3 cycles while a transfer completes in the first cycle -> IF/ID frozen; the held word enters IF/ID on release; no word is lost or duplicated.
- `CHmux`=1 with `stall`=1 -> PC unchanged, no bubble, `flush_count` unchanged.
- Redirect to 0x200 while `imem_ready`=0 for 2 more cycles -> `imem_addr` stays at the old address, the returned word is dropped, then `imem_addr`=0x200.
- 65 540 accepted flushes -> `flush_count` saturates at 16'hFFFF.
